// File: rtl/fc_argmax_ctrl_if.sv
// Result channel of the FC argmax controller.
// Handshake: the master raises resultValid and holds resultClass, resultScore
// and timeoutErr stable until a rising clock edge at which resultReady is also
// high; that edge completes the transfer. The consumer may hold resultReady high
// in advance, which gives a one-cycle valid pulse.
interface fc_argmax_ctrl_if;
    logic        resultValid;
    logic        resultReady;
    logic [7:0]  resultClass;
    logic [15:0] resultScore;
    logic        timeoutErr;

    modport master (
        output resultValid,
        output resultClass,
        output resultScore,
        output timeoutErr,
        input  resultReady
    );

    modport slave (
        input  resultValid,
        input  resultClass,
        input  resultScore,
        input  timeoutErr,
        output resultReady
    );
endinterface

// File: rtl/fc_argmax_ctrl.sv
// Sequencer for a fully connected layer: kicks the layer, waits for it to
// finish (with a saturating timeout), captures its outputs, then scans one node
// per cycle for the signed maximum and offers the index/value as a result.
module fc_argmax_ctrl #(
    parameter int numNodesOut   = 3,
    parameter int timeoutCycles = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      layerReset,
    output logic                      layerEnable,
    input  logic                      layerFinished,
    input  logic [16*numNodesOut-1:0] layerOutputs,
    fc_argmax_ctrl_if.master          res,
    output logic [2:0]                state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KICK   = 3'd1,
        S_RUN    = 3'd2,
        S_SCAN   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(timeoutCycles);
    localparam logic [7:0]  LAST_IDX    = 8'(numNodesOut - 1);

    state_t                    state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [7:0]                idx_q, idx_d;
    logic [16*numNodesOut-1:0] cap_q, cap_d;
    logic signed [15:0]        max_q, max_d;
    logic [7:0]                max_idx_q, max_idx_d;
    logic [7:0]                class_q, class_d;
    logic [15:0]               score_q, score_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic                      lreset_q, lreset_d;
    logic                      lenable_q, lenable_d;
    logic                      busy_q, busy_d;

    logic signed [15:0]        node_val;
    logic signed [15:0]        cand_val;
    logic [7:0]                cand_idx;
    logic [16:0]               cnt_inc;

    // Next-state and datapath: one captured node is compared per SCAN cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        class_d   = class_q;
        score_d   = score_q;
        valid_d   = valid_q;
        err_d     = err_q;

        node_val = '0;
        for (int i = 0; i < numNodesOut; i++) begin
            if (idx_q == 8'(i)) begin
                node_val = cap_q[16*i +: 16];
            end
        end

        // Node 0 seeds the maximum; only strictly greater values replace it,
        // so ties resolve to the lowest index.
        if (idx_q == 8'd0 || node_val > max_q) begin
            cand_val = node_val;
            cand_idx = idx_q;
        end else begin
            cand_val = max_q;
            cand_idx = max_idx_q;
        end

        cnt_inc = {1'b0, cnt_q} + 17'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KICK;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_KICK: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_inc[15:0];
                // A finish on the expiring edge still counts as success.
                if (layerFinished) begin
                    cap_d   = layerOutputs;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end else if (cnt_inc >= TIMEOUT_LIM) begin
                    err_d   = 1'b1;
                    class_d = '0;
                    score_d = '0;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_SCAN: begin
                max_d     = cand_val;
                max_idx_d = cand_idx;
                idx_d     = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    class_d = cand_idx;
                    score_d = cand_val;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (res.resultReady) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Layer controls and busy are registered from the state being entered.
        lreset_d  = (state_d == S_KICK);
        lenable_d = (state_d == S_KICK) || (state_d == S_RUN);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            cap_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            class_q   <= '0;
            score_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            lreset_q  <= 1'b0;
            lenable_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cap_q     <= cap_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            class_q   <= class_d;
            score_q   <= score_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            lreset_q  <= lreset_d;
            lenable_q <= lenable_d;
            busy_q    <= busy_d;
        end
    end

    assign busy            = busy_q;
    assign layerReset      = lreset_q;
    assign layerEnable     = lenable_q;
    assign res.resultValid = valid_q;
    assign res.resultClass = class_q;
    assign res.resultScore = score_q;
    assign res.timeoutErr  = err_q;
    assign state_o         = state_q;

endmodule
